// File: rtl/dmem_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_responder_if: datapath load/store port of the single-cycle MIPS core   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface dmem_responder_if;
  logic        memWrite;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;

  modport master (
    output memWrite,
    output address,
    output writeData,
    input  readData
  );

  modport slave (
    input  memWrite,
    input  address,
    input  writeData,
    output readData
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dmem_responder: word RAM with combinational read; optional MMIO block       |
// | (cycle counter, 8-bit output port, sticky error) enabled by DMEM_MMIO_EN.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module dmem_responder #(
  parameter int unsigned DEPTH   = 64,
  parameter logic [31:0] IO_BASE = 32'hFFFF_0000
) (
  input  wire logic        clk,
  input  wire logic        reset,
  dmem_responder_if.slave  bus,
  output logic [7:0]       io_out,
  output logic             err
);

  localparam int unsigned c_AW        = $clog2(DEPTH);
  localparam logic [31:0] c_RAM_BYTES = 32'(DEPTH * 4);

  logic [31:0]     r_mem [DEPTH];
  logic            r_err;
  logic            w_aligned;
  logic            w_ram_hit;
  logic            w_io_win;
  logic            w_access_ok;
  logic            w_err_set;
  logic            w_err_clr;
  logic [c_AW-1:0] w_idx;
  logic [31:0]     w_rdata;

  assign w_aligned = (bus.address[1:0] == 2'b00);
  assign w_ram_hit = w_aligned && (bus.address < c_RAM_BYTES);
  assign w_io_win  = (bus.address[31:4] == IO_BASE[31:4]);
  assign w_idx     = bus.address[c_AW+1:2];

`ifdef DMEM_MMIO_EN
  logic [31:0] r_cycle;
  logic [7:0]  r_io_out;
  logic        w_io_reg;
  logic        w_wr_cycle;
  logic        w_wr_ioout;
  logic        w_wr_status;

  // Word offset 3 of the window is a hole and counts as unmapped.
  assign w_io_reg    = w_aligned && w_io_win && (bus.address[3:2] != 2'd3);
  assign w_wr_cycle  = bus.memWrite && w_io_reg && (bus.address[3:2] == 2'd0);
  assign w_wr_ioout  = bus.memWrite && w_io_reg && (bus.address[3:2] == 2'd1);
  assign w_wr_status = bus.memWrite && w_io_reg && (bus.address[3:2] == 2'd2);
  assign w_access_ok = w_ram_hit || w_io_reg;
  assign w_err_clr   = w_wr_status && bus.writeData[0];
  assign io_out      = r_io_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycle  <= '0;
      r_io_out <= '0;
    end else begin
      r_cycle <= w_wr_cycle ? bus.writeData : r_cycle + 32'd1;
      if (w_wr_ioout) begin
        r_io_out <= bus.writeData[7:0];
      end
    end
  end
`else
  // IO_BASE never overlaps RAM, so the window term only keeps the decode explicit.
  assign w_access_ok = w_ram_hit && !w_io_win;
  assign w_err_clr   = 1'b0;
  assign io_out      = '0;
`endif

  assign w_err_set = bus.memWrite && !w_access_ok;

  always_comb begin
    w_rdata = '0;
    if (w_ram_hit) begin
      w_rdata = r_mem[w_idx];
    end
`ifdef DMEM_MMIO_EN
    else if (w_io_reg) begin
      case (bus.address[3:2])
        2'd0:    w_rdata = r_cycle;
        2'd1:    w_rdata = {24'b0, r_io_out};
        default: w_rdata = {31'b0, r_err};
      endcase
    end
`endif
  end

  assign bus.readData = w_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (bus.memWrite && w_ram_hit) begin
      r_mem[w_idx] <= bus.writeData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end else if (w_err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// Randomized scoreboard bench for dmem_responder: the driver pushes expected
// readData/io_out/err from an array model; a negedge monitor pops and compares.
module tb_dmem_responder;
  localparam int          DEPTH   = 64;
  localparam logic [31:0] IO_BASE = 32'hFFFF_0000;
`ifdef DMEM_MMIO_EN
  localparam bit MMIO = 1'b1;
`else
  localparam bit MMIO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] io_out;
  logic       err;

  dmem_responder_if bus ();

  dmem_responder #(.DEPTH(DEPTH), .IO_BASE(IO_BASE)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .io_out (io_out),
    .err    (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic [7:0]  io;
    logic        er;
    int          id;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad   = 0;
  int          step_id = 0;

  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_cyc;
  logic [7:0]  m_io;
  logic        m_err;

  function automatic bit is_io(input logic [31:0] a);
    return MMIO && (a[1:0] == 2'b00) && (a >= IO_BASE) && (a < IO_BASE + 32'd12);
  endfunction

  function automatic bit is_ram(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a < 32'(DEPTH * 4));
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (is_ram(a)) return m_mem[int'(a >> 2)];
    if (is_io(a)) begin
      case (int'((a - IO_BASE) >> 2))
        0:       return m_cyc;
        1:       return {24'b0, m_io};
        default: return {31'b0, m_err};
      endcase
    end
    return 32'b0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_cyc = '0;
    m_io  = '0;
    m_err = 1'b0;
  endtask

  task automatic m_edge(input logic mw, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] nc;
    nc = m_cyc + 32'd1;
    if (mw) begin
      if (is_ram(a)) m_mem[int'(a >> 2)] = wd;
      else if (is_io(a)) begin
        case (int'((a - IO_BASE) >> 2))
          0:       nc = wd;
          1:       m_io = wd[7:0];
          default: if (wd[0]) m_err = 1'b0;
        endcase
      end else m_err = 1'b1;
    end
    if (MMIO) m_cyc = nc;
  endtask

  // One cycle: drive at posedge+1, push expectation, model the edge.
  task automatic step(input logic rst_v, input logic mw, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    reset         = rst_v;
    bus.memWrite  = mw;
    bus.address   = a;
    bus.writeData = wd;
    if (!rst_v) m_reset();
    e.rd = m_read(a);
    e.io = MMIO ? m_io : 8'h00;
    e.er = m_err;
    e.id = step_id;
    step_id++;
    sbq.push_back(e);
    @(posedge clk);
    if (rst_v) m_edge(mw, a, wd);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        total++;
        if (bus.readData !== e.rd) begin
          bad++;
          $display("FAIL readData step %0d addr %h: got %h want %h", e.id, bus.address, bus.readData, e.rd);
        end
        total++;
        if (io_out !== e.io) begin
          bad++;
          $display("FAIL io_out step %0d: got %h want %h", e.id, io_out, e.io);
        end
        total++;
        if (err !== e.er) begin
          bad++;
          $display("FAIL err step %0d: got %b want %b", e.id, err, e.er);
        end
      end
    end
  end

  initial begin : driver
    logic [31:0] a;
    logic        mw;
    logic        rv;
    int          kind;
    bus.memWrite  = 1'b0;
    bus.address   = '0;
    bus.writeData = '0;
    m_reset();
    @(posedge clk);
    #1;

    repeat (3) step(1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 32'hFC, 32'h0);
    step(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    step(1'b1, 1'b0, 32'h10, 32'h0);
    step(1'b1, 1'b0, 32'h14, 32'h0);
    step(1'b1, 1'b1, 32'h12, 32'h1234);
    step(1'b1, 1'b0, 32'h10, 32'h0);
    step(1'b1, 1'b1, 32'h100, 32'h5);
    step(1'b1, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b1, IO_BASE, 32'hFFFF_FFFE);
    repeat (3) step(1'b1, 1'b0, IO_BASE, 32'h0);
    step(1'b1, 1'b1, IO_BASE + 32'd4, 32'h1A5);
    step(1'b1, 1'b0, IO_BASE + 32'd4, 32'h0);
    step(1'b1, 1'b1, 32'h13, 32'h0);
    step(1'b1, 1'b1, IO_BASE + 32'd8, 32'h1);
    step(1'b1, 1'b0, IO_BASE + 32'd8, 32'h0);
    step(1'b1, 1'b1, 32'h11, 32'h0);
    step(1'b1, 1'b1, IO_BASE + 32'd8, 32'h0);
    step(1'b1, 1'b0, IO_BASE + 32'd8, 32'h0);
    step(1'b1, 1'b1, 32'h20, 32'h1111_2222);
    step(1'b1, 1'b1, IO_BASE + 32'd4, 32'h3C);
    step(1'b1, 1'b0, 32'h20, 32'h0);
    step(1'b0, 1'b0, 32'h20, 32'h0);
    step(1'b1, 1'b0, IO_BASE, 32'h0);
    step(1'b1, 1'b0, IO_BASE, 32'h0);
    step(1'b1, 1'b0, IO_BASE + 32'd12, 32'h0);

    for (int n = 0; n < 600; n++) begin
      kind = int'($urandom_range(0, 9));
      case (kind)
        0, 1, 2, 3, 4: a = 32'($urandom_range(0, DEPTH - 1)) << 2;
        5:             a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
        6:             a = 32'(DEPTH * 4) + (32'($urandom_range(0, 1023)) << 2);
        7, 8:          a = IO_BASE + (32'($urandom_range(0, 3)) << 2);
        default:       a = IO_BASE + 32'($urandom_range(0, 15));
      endcase
      mw = 1'($urandom_range(0, 1));
      rv = ($urandom_range(0, 49) != 0);
      step(rv, mw, a, $urandom);
    end

    step(1'b1, 1'b0, 32'h0, 32'h0);
    #10;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard drain: got %0d pending want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the single-cycle MIPS core: the slave end of the datapath's load/store port. It receives the ALU-computed address, store data and write strobe, and returns load data combinationally in the same cycle. It holds a word-addressed register-array RAM and, optionally, a small memory-mapped I/O block: a free-running cycle counter, an 8-bit output port and a sticky access-error status.

## Interface
- DEPTH, 64: RAM size in 32-bit words; power of two, 4..1024.
- IO_BASE, 32'hFFFF_0000: byte base address of the MMIO block; 16-byte aligned, outside RAM range.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- memWrite  input  1  store strobe; a write commits at the clk rising edge.
- address  input  32  byte address from the datapath ALU output.
- writeData  input  32  store data (register file second read port).
- readData  output  32  load data, combinational from address.
- io_out  output  8  MMIO output port register.
- err  output  1  sticky access-error flag.

## Operation
- Word index = address[log2(DEPTH)+1:2]. RAM hit: address < DEPTH*4 and address[1:0]==0.
- Misaligned (address[1:0]!=0): readData=0; write ignored; err sets at the edge if memWrite=1.
- Unmapped (not RAM, not an enabled MMIO register): readData=0; write ignored; err sets if memWrite=1. Reads never set err.
- RAM read: readData=mem[index], combinational, no clock.
- RAM write: mem[index]<=writeData at the edge when memWrite=1 and the access is a hit.
- MMIO map (word offsets from IO_BASE):
  - +0x0 CYCLE: 32-bit counter, +1 every edge, wraps 0xFFFF_FFFF->0. A write loads writeData; the loaded value is visible next cycle and increments from there.
  - +0x4 IOOUT: a write loads writeData[7:0] into io_out; a read returns {24'b0, io_out}.
  - +0x8 STATUS: read = {31'b0, err}; writing with writeData[0]=1 clears err; writing 0 has no effect.
  - +0xC: unmapped.
- err priority: a set event and a clear in the same cycle cannot coincide, since a STATUS write is a valid access. err stays 1 until it is cleared or reset.

## Timing
- Read latency 0 cycles (combinational). Write latency 1 edge.
- Read and write to the same address in one cycle: readData shows the old value; the new value is visible after the edge.
- Reset (reset=0, asynchronous, immediate): all RAM words=0, CYCLE=0, io_out=0, err=0. readData is then 0 for any RAM address. Writes are blocked while reset=0.
- Reset deasserted mid-program: CYCLE reads 0 in the first cycle after release and 1 after the next edge.
- No stall or handshake; every access completes in the cycle it is presented.

## Configuration
- DMEM_MMIO_EN defined: the CYCLE, IOOUT and STATUS registers exist as above.
- DMEM_MMIO_EN undefined:
  - No counter and no IOOUT register exist; io_out is tied to 0.
  - All IO_BASE addresses are unmapped (reads return 0; writes set err).
  - err is still driven, but only reset can clear it.

## Test plan
- Reset then reads: reset=0 for 3 cycles, release, read address 0x0 and 0xFC -> readData=0, io_out=0, err=0.
- RAM store/load: write 0xDEADBEEF to 0x10; same cycle readData=0; next cycle read 0x10 -> 0xDEADBEEF; read 0x14 -> 0.
- Misaligned and out-of-range stores:
  - Write 0x1234 to 0x12 -> err=1 after the edge; 0x10 unchanged.
  - Write to 0x100 with DEPTH=64 -> ignored; err stays 1.
- Counter (MMIO enabled):
  - Write 0xFFFF_FFFE to IO_BASE -> next cycle reads 0xFFFF_FFFE, then 0xFFFF_FFFF, then 0x0000_0000.
- IOOUT/STATUS (MMIO enabled):
  - Write 0x1A5 to IO_BASE+4 -> io_out=0xA5; read returns 0x0000_00A5.
  - After a misaligned store, write 1 to IO_BASE+8 -> err=0; write 0 -> no change.
- Async reset mid-operation: assert reset=0 between edges after several stores -> err, io_out, CYCLE and RAM read 0 immediately, without waiting for a clk edge.
